// File: rtl/proc_control_unit.sv
// proc_control_unit
// Moore control FSM for the 16-bit processor. A single 4-bit state register
// sequences fetch, decode and execute. Every datapath control line is a
// combinational decode of that register and the loaded instruction word.
module proc_control_unit (
   input  logic        Clk,
   input  logic        Reset,
   input  logic [15:0] IR,
   output logic        PC_Clr,
   output logic        PC_Up,
   output logic        IR_Ld,
   output logic [7:0]  D_Addr,
   output logic        D_Wr,
   output logic        RF_s,
   output logic [3:0]  RF_W_addr,
   output logic        RF_W_en,
   output logic [3:0]  RF_Ra_addr,
   output logic [3:0]  RF_Rb_addr,
   output logic [2:0]  ALU_s0,
   output logic [3:0]  OutState,
   output logic [3:0]  NextState
);

   // State codes are visible on the debug outputs, so they are fixed here.
   typedef enum logic [3:0] {
      S_INIT   = 4'd0,
      S_FETCH  = 4'd1,
      S_DECODE = 4'd2,
      S_NOOP   = 4'd3,
      S_LOADA  = 4'd4,
      S_LOADB  = 4'd5,
      S_STORE  = 4'd6,
      S_ADD    = 4'd7,
      S_SUB    = 4'd8,
      S_HALT   = 4'd9
   } state_t;

   // Opcodes live in IR[15:12]. Codes 0110 through 1111 are unused and behave as NOOP.
   localparam logic [3:0] OP_NOOP  = 4'h0;
   localparam logic [3:0] OP_STORE = 4'h1;
   localparam logic [3:0] OP_LOAD  = 4'h2;
   localparam logic [3:0] OP_ADD   = 4'h3;
   localparam logic [3:0] OP_SUB   = 4'h4;
   localparam logic [3:0] OP_HALT  = 4'h5;

   // ALU function selects
   localparam logic [2:0] ALU_PASS = 3'b000;
   localparam logic [2:0] ALU_ADD  = 3'b001;
   localparam logic [2:0] ALU_SUB  = 3'b010;

   state_t state_reg;
   state_t state_next;

   // Instruction fields. Several instructions reuse the same bit ranges.
   logic [3:0] opcode;
   logic [3:0] field_a;      // IR[11:8]: STORE source, ADD/SUB operand A
   logic [3:0] field_b;      // IR[7:4] : ADD/SUB operand B
   logic [3:0] field_w;      // IR[3:0] : LOAD/ADD/SUB destination
   logic [7:0] store_addr;   // IR[7:0] : STORE memory address
   logic [7:0] load_addr;    // IR[11:4]: LOAD memory address

   assign opcode     = IR[15:12];
   assign field_a    = IR[11:8];
   assign field_b    = IR[7:4];
   assign field_w    = IR[3:0];
   assign store_addr = IR[7:0];
   assign load_addr  = IR[11:4];

   // Next-state logic. Codes 10-15 are unreachable and recover to Init.
   always_comb begin
      state_next = S_INIT;
      case (state_reg)
         S_INIT:   state_next = S_FETCH;
         S_FETCH:  state_next = S_DECODE;
         S_DECODE: begin
            case (opcode)
               OP_NOOP:  state_next = S_NOOP;
               OP_STORE: state_next = S_STORE;
               OP_LOAD:  state_next = S_LOADA;
               OP_ADD:   state_next = S_ADD;
               OP_SUB:   state_next = S_SUB;
               OP_HALT:  state_next = S_HALT;
               default:  state_next = S_NOOP;
            endcase
         end
         S_NOOP:   state_next = S_FETCH;
         S_LOADA:  state_next = S_LOADB;
         S_LOADB:  state_next = S_FETCH;
         S_STORE:  state_next = S_FETCH;
         S_ADD:    state_next = S_FETCH;
         S_SUB:    state_next = S_FETCH;
         S_HALT:   state_next = S_HALT;
         default:  state_next = S_INIT;
      endcase
   end

   // State register. Reset has priority over every transition, including Halt.
   always_ff @(posedge Clk) begin
      if (Reset) begin
         state_reg <= S_INIT;
      end else begin
         state_reg <= state_next;
      end
   end

   // Moore output decode. Every line defaults to 0, so each strobe is high
   // only in the one state that requests it.
   always_comb begin
      PC_Clr     = 1'b0;
      PC_Up      = 1'b0;
      IR_Ld      = 1'b0;
      D_Addr     = 8'h00;
      D_Wr       = 1'b0;
      RF_s       = 1'b0;
      RF_W_addr  = 4'h0;
      RF_W_en    = 1'b0;
      RF_Ra_addr = 4'h0;
      RF_Rb_addr = 4'h0;
      ALU_s0     = ALU_PASS;
      case (state_reg)
         S_INIT: begin
            PC_Clr = 1'b1;
         end
         S_FETCH: begin
            IR_Ld = 1'b1;
            PC_Up = 1'b1;
         end
         S_DECODE: begin
            // Drive the STORE address and source early so the memory and
            // register file have a full cycle of setup before the write.
            D_Addr     = store_addr;
            RF_Ra_addr = field_a;
         end
         S_LOADA: begin
            // The memory read is synchronous. This cycle presents the address only.
            D_Addr    = load_addr;
            RF_s      = 1'b1;
            RF_W_addr = field_w;
         end
         S_LOADB: begin
            // The read data is valid now, so commit it to the register file.
            D_Addr    = load_addr;
            RF_s      = 1'b1;
            RF_W_addr = field_w;
            RF_W_en   = 1'b1;
         end
         S_STORE: begin
            D_Addr     = store_addr;
            RF_Ra_addr = field_a;
            D_Wr       = 1'b1;
         end
         S_ADD: begin
            RF_Ra_addr = field_a;
            RF_Rb_addr = field_b;
            RF_W_addr  = field_w;
            ALU_s0     = ALU_ADD;
            RF_W_en    = 1'b1;
         end
         S_SUB: begin
            RF_Ra_addr = field_a;
            RF_Rb_addr = field_b;
            RF_W_addr  = field_w;
            ALU_s0     = ALU_SUB;
            RF_W_en    = 1'b1;
         end
         default: begin
            // Noop, Halt and the unreachable codes drive no strobes.
         end
      endcase
   end

   assign OutState  = state_reg;
   assign NextState = state_next;

endmodule

// File: tb/tb_proc_control_unit.sv
// tb_proc_control_unit
// Scoreboard bench for the control FSM. Each scenario pushes the expected
// per-cycle output record, derived by hand from the instruction fields.
// It then pops one record per clock and compares it with the DUT outputs.
module tb_proc_control_unit;

   logic        Clk;
   logic        Reset;
   logic [15:0] IR;
   logic        PC_Clr;
   logic        PC_Up;
   logic        IR_Ld;
   logic [7:0]  D_Addr;
   logic        D_Wr;
   logic        RF_s;
   logic [3:0]  RF_W_addr;
   logic        RF_W_en;
   logic [3:0]  RF_Ra_addr;
   logic [3:0]  RF_Rb_addr;
   logic [2:0]  ALU_s0;
   logic [3:0]  OutState;
   logic [3:0]  NextState;

   typedef struct packed {
      logic [3:0] st;
      logic [3:0] nx;
      logic [5:0] strb;   // {PC_Clr, PC_Up, IR_Ld, D_Wr, RF_W_en, RF_s}
      logic [7:0] da;
      logic [3:0] ra;
      logic [3:0] rb;
      logic [3:0] wa;
      logic [2:0] alu;
   } rec_t;

   rec_t sb[$];
   int   total_checks;
   int   passed_checks;

   proc_control_unit dut (
      .Clk        (Clk),
      .Reset      (Reset),
      .IR         (IR),
      .PC_Clr     (PC_Clr),
      .PC_Up      (PC_Up),
      .IR_Ld      (IR_Ld),
      .D_Addr     (D_Addr),
      .D_Wr       (D_Wr),
      .RF_s       (RF_s),
      .RF_W_addr  (RF_W_addr),
      .RF_W_en    (RF_W_en),
      .RF_Ra_addr (RF_Ra_addr),
      .RF_Rb_addr (RF_Rb_addr),
      .ALU_s0     (ALU_s0),
      .OutState   (OutState),
      .NextState  (NextState)
   );

   initial Clk = 1'b0;
   always #5 Clk = ~Clk;

   function automatic rec_t observe();
      rec_t o;
      o.st   = OutState;
      o.nx   = NextState;
      o.strb = {PC_Clr, PC_Up, IR_Ld, D_Wr, RF_W_en, RF_s};
      o.da   = D_Addr;
      o.ra   = RF_Ra_addr;
      o.rb   = RF_Rb_addr;
      o.wa   = RF_W_addr;
      o.alu  = ALU_s0;
      return o;
   endfunction

   task automatic push(input logic [3:0] st, input logic [3:0] nx, input logic [5:0] strb,
                       input logic [7:0] da, input logic [3:0] ra, input logic [3:0] rb,
                       input logic [3:0] wa, input logic [2:0] alu);
      rec_t e;
      e.st = st; e.nx = nx; e.strb = strb; e.da = da;
      e.ra = ra; e.rb = rb; e.wa = wa; e.alu = alu;
      sb.push_back(e);
   endtask

   // Reset held for two edges: Init with only PC_Clr. The next state is Fetch.
   task automatic test_reset();
      rec_t e, o;
      Reset = 1'b1;
      IR    = 16'h0000;
      push(4'd0, 4'd1, 6'b100000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd0, 4'd1, 6'b100000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      for (int k = 0; k < 2; k++) begin
         @(negedge Clk);
         e = sb.pop_front();
         o = observe();
         total_checks++;
         if (o !== e) $display("FAIL reset cyc%0d got %h exp %h", k, o, e);
         else passed_checks++;
      end
      Reset = 1'b0;
   endtask

   // ADD then SUB, back to back: Fetch, Decode, Execute, each 3 cycles.
   task automatic test_add_sub();
      rec_t e, o;
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd2, 4'd7, 6'b000000, 8'h23, 4'h1, 4'h0, 4'h0, 3'b000);
      push(4'd7, 4'd1, 6'b000010, 8'h00, 4'h1, 4'h2, 4'h3, 3'b001);
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd2, 4'd8, 6'b000000, 8'h23, 4'h1, 4'h0, 4'h0, 3'b000);
      push(4'd8, 4'd1, 6'b000010, 8'h00, 4'h1, 4'h2, 4'h3, 3'b010);
      for (int k = 0; k < 6; k++) begin
         @(negedge Clk);
         e = sb.pop_front();
         o = observe();
         total_checks++;
         if (o !== e) $display("FAIL add_sub cyc%0d got %h exp %h", k, o, e);
         else passed_checks++;
         if (k == 0) IR = 16'h3123;
         if (k == 3) IR = 16'h4123;
      end
   endtask

   // LOAD takes 4 cycles. RF_W_en is high only in LoadB.
   task automatic test_load();
      rec_t e, o;
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd2, 4'd4, 6'b000000, 8'hA5, 4'h1, 4'h0, 4'h0, 3'b000);
      push(4'd4, 4'd5, 6'b000001, 8'h1A, 4'h0, 4'h0, 4'h5, 3'b000);
      push(4'd5, 4'd1, 6'b000011, 8'h1A, 4'h0, 4'h0, 4'h5, 3'b000);
      for (int k = 0; k < 4; k++) begin
         @(negedge Clk);
         e = sb.pop_front();
         o = observe();
         total_checks++;
         if (o !== e) $display("FAIL load cyc%0d got %h exp %h", k, o, e);
         else passed_checks++;
         if (k == 0) IR = 16'h21A5;
      end
   endtask

   // STORE: the address and source are pre-driven in Decode. D_Wr is high only in Store.
   task automatic test_store();
      rec_t e, o;
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd2, 4'd6, 6'b000000, 8'h07, 4'hB, 4'h0, 4'h0, 3'b000);
      push(4'd6, 4'd1, 6'b000100, 8'h07, 4'hB, 4'h0, 4'h0, 3'b000);
      for (int k = 0; k < 3; k++) begin
         @(negedge Clk);
         e = sb.pop_front();
         o = observe();
         total_checks++;
         if (o !== e) $display("FAIL store cyc%0d got %h exp %h", k, o, e);
         else passed_checks++;
         if (k == 0) IR = 16'h1B07;
      end
   endtask

   // HALT is held for 20 cycles. Reset returns to Init, then an unused opcode runs as NOOP.
   task automatic test_halt();
      rec_t e, o;
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd2, 4'd9, 6'b000000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      for (int k = 0; k < 20; k++)
         push(4'd9, 4'd9, 6'b000000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd0, 4'd1, 6'b100000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd2, 4'd3, 6'b000000, 8'h23, 4'h1, 4'h0, 4'h0, 3'b000);
      push(4'd3, 4'd1, 6'b000000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      for (int k = 0; k < 26; k++) begin
         @(negedge Clk);
         e = sb.pop_front();
         o = observe();
         total_checks++;
         if (o !== e) $display("FAIL halt cyc%0d got %h exp %h", k, o, e);
         else passed_checks++;
         if (k == 0)  IR = 16'h5000;
         if (k == 21) Reset = 1'b1;
         if (k == 22) Reset = 1'b0;
         if (k == 23) IR = 16'hF123;
      end
   endtask

   // Reset asserted in LoadA: the FSM goes to Init, and LoadB and RF_W_en never appear.
   task automatic test_reset_mid_load();
      rec_t e, o;
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd2, 4'd4, 6'b000000, 8'hA5, 4'h1, 4'h0, 4'h0, 3'b000);
      push(4'd4, 4'd5, 6'b000001, 8'h1A, 4'h0, 4'h0, 4'h5, 3'b000);
      push(4'd0, 4'd1, 6'b100000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      push(4'd1, 4'd2, 6'b011000, 8'h00, 4'h0, 4'h0, 4'h0, 3'b000);
      for (int k = 0; k < 5; k++) begin
         @(negedge Clk);
         e = sb.pop_front();
         o = observe();
         total_checks++;
         if (o !== e) $display("FAIL reset_mid_load cyc%0d got %h exp %h", k, o, e);
         else passed_checks++;
         if (k == 0) IR = 16'h21A5;
         if (k == 2) Reset = 1'b1;
         if (k == 3) Reset = 1'b0;
      end
   endtask

   initial begin
      total_checks  = 0;
      passed_checks = 0;
      Reset = 1'b1;
      IR    = 16'h0000;
      test_reset();
      test_add_sub();
      test_load();
      test_store();
      test_halt();
      test_reset_mid_load();
      total_checks++;
      if (sb.size() !== 0) $display("FAIL scoreboard_drain got %0d exp 0", sb.size());
      else passed_checks++;
      $display("%0d/%0d checks passed", passed_checks, total_checks);
      $finish;
   end

endmodule
